// File: rtl/relm_div_pkg.sv
// Shared types and helpers for the relm_div_seq sequential divider.
// Holds the controller state encoding and the iteration-count helper.
package relm_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    function automatic int relm_div_iters(input int wd, input int rb);
        return wd / rb;
    endfunction

endpackage

// File: rtl/relm_div_step.sv
// One radix-2^RB restoring step: shift RB dividend bits into R and
// subtract the largest multiple j*|D| that still fits.
module relm_div_step #(
    parameter int WD = 32,
    parameter int RB = 2
) (
    input  logic [WD:0]   r_in,
    input  logic [RB-1:0] bits_in,
    input  logic [WD-1:0] d_in,
    output logic [WD:0]   r_out,
    output logic [RB-1:0] j_out
);
    // 3*|D| needs WD+2 bits, and the shifted R always fits in WD+RB bits.
    localparam int CW   = WD + 2;
    localparam int MAXJ = (1 << RB) - 1;

    logic [CW-1:0] r_sh;
    logic [CW-1:0] prod;
    logic [CW-1:0] best;

    always_comb begin
        r_sh  = CW'({r_in, bits_in});
        prod  = '0;
        best  = '0;
        j_out = '0;
        // Multiples grow with j, so the last one that fits is the largest.
        for (int j = 1; j <= MAXJ; j++) begin
            prod = CW'(d_in) * CW'(j);
            if (prod <= r_sh) begin
                best  = prod;
                j_out = RB'(j);
            end
        end
        r_out = (WD + 1)'(r_sh - best);
    end

endmodule

// File: rtl/relm_div_seq.sv
// Self-timed multi-cycle integer divider: start pulse in, fixed-latency
// restoring loop on magnitudes, sign fix-up, done pulse out.
module relm_div_seq
    import relm_div_pkg::*;
#(
    parameter int WD = 32,
    parameter int RB = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    input  logic          signed_in,
    input  logic [WD-1:0] n_in,
    input  logic [WD-1:0] d_in,
    output logic          busy_out,
    output logic          done_out,
    output logic [WD-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          dz_out
);
    localparam int ITERS = relm_div_iters(WD, RB);
    localparam int KW    = $clog2(ITERS + 1);

    div_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [WD-1:0] n_q, n_d;
    logic [WD-1:0] d_q, d_d;
    logic [WD:0]   r_q, r_d;
    logic [WD-1:0] qr_q, qr_d;
    logic          sn_q, sn_d;
    logic          sd_q, sd_d;
    logic          dzp_q, dzp_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [WD-1:0] q_out_q, q_out_d;
    logic [WD-1:0] r_out_q, r_out_d;
    logic          dz_out_q, dz_out_d;

    logic [WD:0]   r_step;
    logic [RB-1:0] j_step;

    relm_div_step #(.WD(WD), .RB(RB)) u_step (
        .r_in    (r_q),
        .bits_in (n_q[WD-1 -: RB]),
        .d_in    (d_q),
        .r_out   (r_step),
        .j_out   (j_step)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        d_d      = d_q;
        r_d      = r_q;
        qr_d     = qr_q;
        sn_d     = sn_q;
        sd_d     = sd_q;
        dzp_d    = dzp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        q_out_d  = q_out_q;
        r_out_d  = r_out_q;
        dz_out_d = dz_out_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    sn_d    = signed_in & n_in[WD-1];
                    sd_d    = signed_in & d_in[WD-1];
                    dzp_d   = (d_in == '0);
                    d_d     = sd_d ? -d_in : d_in;
                    // On divide-by-zero the raw dividend is kept for r_out.
                    n_d     = (sn_d && !dzp_d) ? -n_in : n_in;
                    r_d     = '0;
                    qr_d    = '0;
                    k_d     = KW'(ITERS);
                    busy_d  = 1'b1;
                    state_d = dzp_d ? FIX : LOOP;
                end
            end
            LOOP: begin
                r_d  = r_step;
                n_d  = n_q << RB;
                qr_d = {qr_q[WD-RB-1:0], j_step};
                k_d  = k_q - KW'(1);
                if (k_q == KW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                dz_out_d = dzp_q;
                state_d  = IDLE;
                if (dzp_q) begin
                    q_out_d = '1;
                    r_out_d = n_q;
                end else begin
                    q_out_d = (sn_q ^ sd_q) ? -qr_q : qr_q;
                    r_out_d = sn_q ? -r_q[WD-1:0] : r_q[WD-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            n_q      <= '0;
            d_q      <= '0;
            r_q      <= '0;
            qr_q     <= '0;
            sn_q     <= 1'b0;
            sd_q     <= 1'b0;
            dzp_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            q_out_q  <= '0;
            r_out_q  <= '0;
            dz_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            d_q      <= d_d;
            r_q      <= r_d;
            qr_q     <= qr_d;
            sn_q     <= sn_d;
            sd_q     <= sd_d;
            dzp_q    <= dzp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            q_out_q  <= q_out_d;
            r_out_q  <= r_out_d;
            dz_out_q <= dz_out_d;
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;
    assign q_out    = q_out_q;
    assign r_out    = r_out_q;
    assign dz_out   = dz_out_q;

endmodule

// File: tb/tb_relm_div_seq.sv
// Bench for relm_div_seq: directed 32-bit cases plus a randomized 8-bit sweep
// (RB=1 and RB=2) checked against an arithmetic reference model.
module tb_relm_div_seq;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [31:0] due;
    } exp_t;

    logic clk;
    logic rst;

    logic        st32, s32;
    logic [31:0] n32, d32;
    logic        busy32, done32, dz32;
    logic [31:0] q32, r32;

    logic       st8, s8;
    logic [7:0] n8, d8;
    logic       busy8a, done8a, dz8a, busy8b, done8b, dz8b;
    logic [7:0] q8a, r8a, q8b, r8b;

    exp_t exp32[$];
    exp_t exp8a[$];
    exp_t exp8b[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    relm_div_seq #(.WD(32), .RB(2)) u32 (
        .clk(clk), .rst(rst), .start_in(st32), .signed_in(s32),
        .n_in(n32), .d_in(d32), .busy_out(busy32), .done_out(done32),
        .q_out(q32), .r_out(r32), .dz_out(dz32)
    );

    relm_div_seq #(.WD(8), .RB(1)) u8a (
        .clk(clk), .rst(rst), .start_in(st8), .signed_in(s8),
        .n_in(n8), .d_in(d8), .busy_out(busy8a), .done_out(done8a),
        .q_out(q8a), .r_out(r8a), .dz_out(dz8a)
    );

    relm_div_seq #(.WD(8), .RB(2)) u8b (
        .clk(clk), .rst(rst), .start_in(st8), .signed_in(s8),
        .n_in(n8), .d_in(d8), .busy_out(busy8b), .done_out(done8b),
        .q_out(q8b), .r_out(r8b), .dz_out(dz8b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: truncating division on plain integers, dividend-signed remainder.
    // Done is observed at the falling edge L+1 cycles after the start was driven,
    // with L = WD/RB+1 edges normally and 1 edge when D is zero.
    function automatic exp_t model(input logic [31:0] n, input logic [31:0] d, input logic sg,
                                   input int wd, input int rb, input int c);
        exp_t   e;
        longint mask, ns, ds, qq, rr;
        mask = (longint'(1) << wd) - 1;
        if (d == 32'd0) begin
            e.q   = 32'(mask);
            e.r   = n;
            e.dz  = 1'b1;
            e.due = 32'(c + 2);
        end else begin
            ns = longint'(n);
            ds = longint'(d);
            if (sg && n[wd-1]) ns = ns - (longint'(1) << wd);
            if (sg && d[wd-1]) ds = ds - (longint'(1) << wd);
            qq    = ns / ds;
            rr    = ns % ds;
            e.q   = 32'(qq & mask);
            e.r   = 32'(rr & mask);
            e.dz  = 1'b0;
            e.due = 32'(c + wd / rb + 2);
        end
        return e;
    endfunction

    task automatic chk_res(input string nm, input logic [31:0] q, input logic [31:0] r,
                           input logic dz, input exp_t e);
        check({nm, " q"}, q, e.q);
        check({nm, " r"}, r, e.r);
        check({nm, " dz"}, {31'b0, dz}, {31'b0, e.dz});
        check({nm, " done cycle"}, 32'(cyc), e.due);
    endtask

    // scoreboard: every falling edge, match done pulses against expected queues
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (done32) begin
                if (exp32.size() == 0) check("u32 spurious done", {31'b0, done32}, 32'd0);
                else begin e = exp32.pop_front(); chk_res("u32", q32, r32, dz32, e); end
            end else if (exp32.size() != 0 && 32'(cyc) > exp32[0].due) begin
                e = exp32.pop_front();
                check("u32 done timeout", {31'b0, done32}, 32'd1);
            end
            if (done8a) begin
                if (exp8a.size() == 0) check("u8a spurious done", {31'b0, done8a}, 32'd0);
                else begin e = exp8a.pop_front(); chk_res("u8a", {24'b0, q8a}, {24'b0, r8a}, dz8a, e); end
            end else if (exp8a.size() != 0 && 32'(cyc) > exp8a[0].due) begin
                e = exp8a.pop_front();
                check("u8a done timeout", {31'b0, done8a}, 32'd1);
            end
            if (done8b) begin
                if (exp8b.size() == 0) check("u8b spurious done", {31'b0, done8b}, 32'd0);
                else begin e = exp8b.pop_front(); chk_res("u8b", {24'b0, q8b}, {24'b0, r8b}, dz8b, e); end
            end else if (exp8b.size() != 0 && 32'(cyc) > exp8b[0].due) begin
                e = exp8b.pop_front();
                check("u8b done timeout", {31'b0, done8b}, 32'd1);
            end
        end
    end

    // driver tasks: called right after a falling edge
    task automatic start32(input logic [31:0] n, input logic [31:0] d, input logic s);
        #1;
        n32  = n;
        d32  = d;
        s32  = s;
        st32 = 1'b1;
        exp32.push_back(model(n, d, s, 32, 2, cyc));
        @(negedge clk);
        #1 st32 = 1'b0;
    endtask

    task automatic wait32(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done32) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run8(input logic [7:0] n, input logic [7:0] d, input logic s);
        #1;
        n8  = n;
        d8  = d;
        s8  = s;
        st8 = 1'b1;
        exp8a.push_back(model({24'b0, n}, {24'b0, d}, s, 8, 1, cyc));
        exp8b.push_back(model({24'b0, n}, {24'b0, d}, s, 8, 2, cyc));
        @(negedge clk);
        #1 st8 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp8a.size() == 0 && exp8b.size() == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, " busy"}, {31'b0, busy32}, 32'd0);
        check({nm, " done"}, {31'b0, done32}, 32'd0);
        check({nm, " q"}, q32, 32'd0);
        check({nm, " r"}, r32, 32'd0);
        check({nm, " dz"}, {31'b0, dz32}, 32'd0);
    endtask

    // main stimulus
    initial begin
        int         lat;
        int         ndone;
        exp_t       e;
        logic [7:0] corners [6];
        logic [7:0] nv, dv;
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};

        rst = 1'b1;
        st32 = 1'b0; s32 = 1'b0; n32 = '0; d32 = '0;
        st8 = 1'b0; s8 = 1'b0; n8 = '0; d8 = '0;

        // pin the model with hand-computed values
        e = model(32'hFFFFFFF9, 32'd2, 1'b1, 32, 2, 0);
        check("model -7/2 q", e.q, 32'hFFFFFFFD);
        check("model -7/2 r", e.r, 32'hFFFFFFFF);
        e = model(32'h80000000, 32'hFFFFFFFF, 1'b1, 32, 2, 0);
        check("model min/-1 q", e.q, 32'h80000000);
        check("model min/-1 r", e.r, 32'd0);

        repeat (2) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;

        @(negedge clk);
        start32(32'd100, 32'd7, 1'b0);
        wait32(lat);
        check("100/7 latency", 32'(lat), 32'd17);
        check("100/7 q", q32, 32'd14);
        check("100/7 r", r32, 32'd2);
        check("100/7 busy in done cycle", {31'b0, busy32}, 32'd0);

        @(negedge clk);
        start32(32'hFFFFFFF9, 32'd2, 1'b1);
        wait32(lat);
        check("-7/2 q", q32, 32'hFFFFFFFD);
        check("-7/2 r", r32, 32'hFFFFFFFF);

        @(negedge clk);
        start32(32'd7, 32'hFFFFFFFE, 1'b1);
        wait32(lat);
        check("7/-2 q", q32, 32'hFFFFFFFD);
        check("7/-2 r", r32, 32'd1);

        // D==0 skips LOOP: FIX happens on the first edge after the start edge
        @(negedge clk);
        start32(32'h1234, 32'd0, 1'b0);
        wait32(lat);
        check("div0 latency", 32'(lat), 32'd1);
        check("div0 q", q32, 32'hFFFFFFFF);
        check("div0 r", r32, 32'h1234);
        check("div0 dz", {31'b0, dz32}, 32'd1);

        @(negedge clk);
        start32(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait32(lat);
        check("min/-1 q", q32, 32'h80000000);
        check("min/-1 r", r32, 32'd0);
        check("min/-1 dz", {31'b0, dz32}, 32'd0);

        @(negedge clk);
        start32(32'hFFFFFFFF, 32'd1, 1'b0);
        wait32(lat);
        check("ffffffff/1 q", q32, 32'hFFFFFFFF);
        check("ffffffff/1 r", r32, 32'd0);

        // start while busy is dropped; start in the done cycle is taken
        @(negedge clk);
        start32(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        #1 n32 = 32'd9; d32 = 32'd3; st32 = 1'b1;
        @(negedge clk);
        #1 st32 = 1'b0;
        wait32(lat);
        check("overlap first q", q32, 32'd14);
        check("overlap first r", r32, 32'd2);
        start32(32'd9, 32'd3, 1'b0);
        wait32(lat);
        check("back2back latency", 32'(lat), 32'd17);
        check("back2back q", q32, 32'd3);
        check("back2back r", r32, 32'd0);

        // reset in mid-operation
        @(negedge clk);
        start32(32'd100, 32'd7, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        exp32.delete();
        rst = 1'b1;
        #1 check_zero("mid reset");
        @(negedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        check("no done after reset", 32'(ndone), 32'd0);
        start32(32'd45, 32'd6, 1'b0);
        wait32(lat);
        check("after reset latency", 32'(lat), 32'd17);
        check("after reset q", q32, 32'd7);
        check("after reset r", r32, 32'd3);

        // 8-bit sweep, RB=1 and RB=2 side by side
        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            nv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
            dv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
            run8(nv, dv, 1'($urandom_range(0, 1)));
        end
        run8(8'h80, 8'hFF, 1'b1);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h81, 8'h00, 1'b1);

        repeat (20) @(negedge clk);
        check("u32 queue drained", 32'(exp32.size()), 32'd0);
        check("u8a queue drained", 32'(exp8a.size()), 32'd0);
        check("u8b queue drained", 32'(exp8b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
